// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// ALU operation codes and the bundle of datapath strobes.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RALU  = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       shift;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  // Opcodes 0000..0110 are the ALU/memory/branch group; 1111 is HALT.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_BEQ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles a memory request goes unanswered and flags expiry on the
// WAIT_MAX-th consecutive wait cycle.
module mem_watchdog #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] count;

  assign expire = inc && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM driving the shared-memory,
// single-ALU datapath; outputs are Moore except the MemReady/Zero-qualified writes.
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             shift,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  // Memory handshake: an access is in flight while mem_req=1; it completes in
  // the cycle mem_ready=1. mem_ready with mem_req=0 has no effect.

  state_t           state, next_state;
  logic [3:0]       op_reg;
  logic [CNT_W-1:0] retired_q;
  logic             fault_q;
  logic             retire_inc;
  logic             expire;
  logic             wd_clear;
  ctrl_t            ctrl, ctrl_o;

  always_comb begin
    ctrl       = '0;
    next_state = state;
    retire_inc = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        if (expire) begin
          next_state = S_HALT;
        end else if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          next_state = S_HALT;
        end else if (!op_legal(opcode)) begin
          ctrl.illegal = 1'b1;
          retire_inc   = 1'b1;
          next_state   = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        next_state = S_WB;
        case (op_reg)
          OP_RALU:  ctrl.alu_op = ALU_FUNCT;
          OP_SHIFT: begin
            ctrl.alu_op = ALU_FUNCT;
            ctrl.shift  = 1'b1;
          end
          OP_ADDI:  ctrl.alu_src = 1'b1;
          OP_ANDI:  begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_AND;
          end
          OP_LW, OP_SW: begin
            ctrl.alu_src = 1'b1;
            next_state   = S_MEM;
          end
          OP_BEQ: begin
            ctrl.alu_op   = ALU_SUB;
            ctrl.pc_src   = 1'b1;
            ctrl.pc_write = zero;
            retire_inc    = 1'b1;
            next_state    = S_FETCH;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Strobes depend only on op_reg, so they stay stable across wait cycles.
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = (op_reg == OP_LW);
        ctrl.mem_write = (op_reg == OP_SW);
        if (expire) begin
          next_state = S_HALT;
        end else if (mem_ready) begin
          if (op_reg == OP_LW) begin
            next_state = S_WB;
          end else begin
            retire_inc = 1'b1;
            next_state = S_FETCH;
          end
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_reg == OP_RALU) || (op_reg == OP_SHIFT);
        ctrl.mem_to_reg = (op_reg == OP_LW);
        ctrl.shift      = (op_reg == OP_SHIFT);
        retire_inc      = 1'b1;
        next_state      = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Counter restarts when an access phase begins or an access completes.
  assign wd_clear = mem_ready ||
                    ((next_state != state) &&
                     ((next_state == S_FETCH) || (next_state == S_MEM)));

  mem_watchdog #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .inc    (ctrl.mem_req && !mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      op_reg    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_reg <= opcode;
      if (retire_inc) retired_q <= retired_q + 1'b1;
      if (expire) fault_q <= 1'b1;
    end
  end

  // Reset forces every output low, including mid-access.
  assign ctrl_o     = reset ? '0 : ctrl;
  assign mem_req    = ctrl_o.mem_req;
  assign iord       = ctrl_o.iord;
  assign ir_write   = ctrl_o.ir_write;
  assign pc_write   = ctrl_o.pc_write;
  assign pc_src     = ctrl_o.pc_src;
  assign reg_dst    = ctrl_o.reg_dst;
  assign reg_write  = ctrl_o.reg_write;
  assign mem_read   = ctrl_o.mem_read;
  assign mem_write  = ctrl_o.mem_write;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign alu_src    = ctrl_o.alu_src;
  assign shift      = ctrl_o.shift;
  assign alu_op     = ctrl_o.alu_op;
  assign halted     = ctrl_o.halted;
  assign illegal    = ctrl_o.illegal;
  assign fault      = fault_q && !reset;
  assign retired    = reset ? '0 : retired_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle expected output vectors are queued
// by the driver from an instruction-level model and checked by a negedge monitor.
module tb_multicycle_sequencer;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 8;
  localparam int W        = 17 + CNT_W;

  localparam int P_RST    = 0;
  localparam int P_FETCH  = 1;
  localparam int P_DECODE = 2;
  localparam int P_EXEC   = 3;
  localparam int P_MEM    = 4;
  localparam int P_WB     = 5;
  localparam int P_HALT   = 6;

  logic             clk;
  logic             reset;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, iord, ir_write, pc_write, pc_src, reg_dst, reg_write;
  logic             mem_read, mem_write, mem_to_reg, alu_src, shift;
  logic [1:0]       alu_op;
  logic             halted, fault, illegal;
  logic [CNT_W-1:0] retired;
  logic [2:0]       dbg_state;

  multicycle_sequencer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .shift      (shift),
    .alu_op     (alu_op),
    .halted     (halted),
    .fault      (fault),
    .illegal    (illegal),
    .retired    (retired),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_vec;
  int           n_cmp;
  int           n_bad;
  int           cyc_no;
  bit           mon_en;
  int unsigned  n_retired;
  bit           fault_m;

  assign act_vec = {mem_req, iord, ir_write, pc_write, pc_src, reg_dst, reg_write,
                    mem_read, mem_write, mem_to_reg, alu_src, shift, alu_op,
                    halted, fault, illegal, retired};

  // Expected outputs for one cycle of an instruction phase, straight from the
  // opcode/phase tables of the control description.
  function automatic logic [W-1:0] model_vec(input int ph, input logic [3:0] op,
                                             input logic z, input logic rdy);
    logic mreq, mio, irw, pcw, psrc, rdst, rw, mrd, mwr, m2r, asrc, sh, hlt, ill;
    logic [1:0] aop;
    {mreq, mio, irw, pcw, psrc, rdst, rw, mrd, mwr, m2r, asrc, sh, hlt, ill} = '0;
    aop = 2'b00;
    if (ph == P_RST) return '0;
    case (ph)
      P_FETCH: begin
        mreq = 1; mrd = 1; asrc = 1;
        if (rdy) begin irw = 1; pcw = 1; end
      end
      P_DECODE: ill = !((op <= 4'd6) || (op == 4'hF));
      P_EXEC: begin
        if (op == 4'd0) aop = 2'b10;
        if (op == 4'd1) begin aop = 2'b10; sh = 1; end
        if (op == 4'd2 || op == 4'd4 || op == 4'd5) asrc = 1;
        if (op == 4'd3) begin asrc = 1; aop = 2'b11; end
        if (op == 4'd6) begin aop = 2'b01; psrc = 1; pcw = z; end
      end
      P_MEM: begin
        mreq = 1; mio = 1; mrd = (op == 4'd4); mwr = (op == 4'd5);
      end
      P_WB: begin
        rw = 1; rdst = (op <= 4'd1); m2r = (op == 4'd4); sh = (op == 4'd1);
      end
      P_HALT: hlt = 1;
      default: ;
    endcase
    return {mreq, mio, irw, pcw, psrc, rdst, rw, mrd, mwr, m2r, asrc, sh, aop,
            hlt, fault_m, ill, CNT_W'(n_retired)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow cycle %0d: got %h, nothing expected", cyc_no, act_vec);
      end else begin
        e = exp_q.pop_front();
        if (act_vec !== e) begin
          n_bad++;
          $display("FAIL sb_cycle %0d: got %h expected %h", cyc_no, act_vec, e);
        end
      end
      cyc_no++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, advance.
  task automatic cyc(input int ph, input logic [3:0] op, input logic z, input logic rdy);
    mem_ready = rdy;
    opcode    = (ph == P_DECODE) ? op : 4'($urandom_range(0, 15));
    zero      = (ph == P_EXEC) ? z : 1'($urandom_range(0, 1));
    exp_q.push_back(model_vec(ph, op, z, rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cyc(P_RST, 4'd0, 1'b0, 1'b0);
    reset     = 1'b0;
    n_retired = 0;
    fault_m   = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(P_HALT, 4'd0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Plays one instruction; returns early if the watchdog trips or HALT decodes.
  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin
      cyc(P_FETCH, op, z, 1'b0);
      if (i + 1 == WAIT_MAX) begin fault_m = 1'b1; return; end
    end
    cyc(P_FETCH, op, z, 1'b1);
    cyc(P_DECODE, op, z, 1'($urandom_range(0, 1)));
    if (op == 4'hF) return;
    if (op > 4'd6) begin n_retired++; return; end
    cyc(P_EXEC, op, z, 1'($urandom_range(0, 1)));
    if (op == 4'd6) begin n_retired++; return; end
    if (op == 4'd4 || op == 4'd5) begin
      for (int i = 0; i < mw; i++) begin
        cyc(P_MEM, op, z, 1'b0);
        if (i + 1 == WAIT_MAX) begin fault_m = 1'b1; return; end
      end
      cyc(P_MEM, op, z, 1'b1);
      if (op == 4'd5) begin n_retired++; return; end
    end
    cyc(P_WB, op, z, 1'($urandom_range(0, 1)));
    n_retired++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0; cyc_no = 0; mon_en = 1'b0;
    n_retired = 0; fault_m = 1'b0;
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(3);

    // Directed: R-ALU, LW with memory waits, BEQ taken/not, illegal, SW with fetch wait.
    run_instr(4'd0, 1'b0, 0, 0);
    run_instr(4'd4, 1'b0, 0, 2);
    run_instr(4'd6, 1'b1, 0, 0);
    run_instr(4'd6, 1'b0, 0, 0);
    run_instr(4'hA, 1'b0, 0, 0);
    run_instr(4'd5, 1'b0, 1, 0);
    run_instr(4'd1, 1'b0, 0, 0);
    run_instr(4'd3, 1'b0, 2, 0);

    // Random mix long enough to wrap the retired counter.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr(op, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WAIT_MAX - 1)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WAIT_MAX - 1)) : 0);
    end

    // Watchdog in FETCH, then in MEM of LW.
    run_instr(4'd0, 1'b0, WAIT_MAX, 0);
    halt_cycles(3);
    do_reset(2);
    run_instr(4'd2, 1'b0, 0, 0);
    run_instr(4'd4, 1'b0, 0, WAIT_MAX);
    halt_cycles(2);
    do_reset(1);

    // Reset while SW is waiting in MEM.
    run_instr(4'd0, 1'b0, 0, 0);
    cyc(P_FETCH, 4'd5, 1'b0, 1'b1);
    cyc(P_DECODE, 4'd5, 1'b0, 1'b0);
    cyc(P_EXEC, 4'd5, 1'b0, 1'b0);
    cyc(P_MEM, 4'd5, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(P_RST, 4'd0, 1'b0, 1'b0);
    check("state_after_mid_reset", 32'(dbg_state), 32'd0);
    do_reset(1);
    run_instr(4'd5, 1'b0, 0, 0);

    // HALT opcode sticks until reset.
    run_instr(4'hF, 1'b0, 0, 0);
    halt_cycles(4);
    do_reset(1);
    check("state_after_halt_reset", 32'(dbg_state), 32'd0);
    run_instr(4'd2, 1'b0, 0, 0);

    mon_en = 1'b0;
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
